// File: rtl/csr_abstract_cmd.sv
// Debug abstract "access register" initiator: turns one command into one CSR read/write.
// Optional CSR_AC_TIMEOUT_EN adds an ack timeout that answers with cmderr 7.
module csr_abstract_cmd #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            CmdValid,
  output logic            CmdReady,
  input  logic            CmdWrite,
  input  logic [11:0]     CmdRegno,
  input  logic [XLEN-1:0] CmdData,
  input  logic            Halted,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] RspData,
  output logic [2:0]      RspErr,
  output logic            Busy,
  output logic            CSRReq,
  output logic            CSRWrite,
  output logic [11:0]     CSRAdr,
  output logic [XLEN-1:0] CSRWriteVal,
  input  logic            CSRAck,
  input  logic [XLEN-1:0] CSRReadVal,
  input  logic            CSRIllegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_EXC  = 3'd3;
  localparam logic [2:0] ERR_HALT = 3'd4;
`ifdef CSR_AC_TIMEOUT_EN
  localparam logic [2:0] ERR_TMO  = 3'd7;
`endif

  localparam int unsigned CNT_W = 8;

  // Reject unsupported configurations at elaboration.
  if ((XLEN != 32 && XLEN != 64) || TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_param
    $error("csr_abstract_cmd: unsupported XLEN or TIMEOUT");
  end

  logic [1:0]      state, state_d;
  logic            cmd_ready_d, rsp_valid_d, busy_d;
  logic [XLEN-1:0] rsp_data_d;
  logic [2:0]      rsp_err_d;
  logic            csr_req_d, csr_write_d;
  logic [11:0]     csr_adr_d;
  logic [XLEN-1:0] csr_wval_d;
`ifdef CSR_AC_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      CmdReady    <= 1'b0;
      RspValid    <= 1'b0;
      RspData     <= '0;
      RspErr      <= '0;
      Busy        <= 1'b0;
      CSRReq      <= 1'b0;
      CSRWrite    <= 1'b0;
      CSRAdr      <= '0;
      CSRWriteVal <= '0;
`ifdef CSR_AC_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state       <= state_d;
      CmdReady    <= cmd_ready_d;
      RspValid    <= rsp_valid_d;
      RspData     <= rsp_data_d;
      RspErr      <= rsp_err_d;
      Busy        <= busy_d;
      CSRReq      <= csr_req_d;
      CSRWrite    <= csr_write_d;
      CSRAdr      <= csr_adr_d;
      CSRWriteVal <= csr_wval_d;
`ifdef CSR_AC_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d     = state;
    rsp_valid_d = RspValid;
    rsp_data_d  = RspData;
    rsp_err_d   = RspErr;
    csr_req_d   = CSRReq;
    csr_write_d = CSRWrite;
    csr_adr_d   = CSRAdr;
    csr_wval_d  = CSRWriteVal;
`ifdef CSR_AC_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state)
      S_IDLE: begin
        if (CmdValid && CmdReady) begin
          csr_write_d = CmdWrite;
          csr_adr_d   = CmdRegno;
          csr_wval_d  = CmdData;
          if (!Halted) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = ERR_HALT;
          end else if (CmdWrite && (CmdRegno[11:10] == 2'b11)) begin
            // Top quarter of CSR space is read-only; refuse without a bus cycle.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = ERR_EXC;
          end else begin
            state_d   = S_ISSUE;
            csr_req_d = 1'b1;
`ifdef CSR_AC_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (CSRAck) begin
          state_d     = S_RESP;
          csr_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = CSRIllegal ? ERR_EXC : ERR_NONE;
          rsp_data_d  = (CSRIllegal || CSRWrite) ? '0 : CSRReadVal;
        end
`ifdef CSR_AC_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d     = S_RESP;
          csr_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (RspReady) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        csr_req_d   = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_csr_abstract_cmd.sv
// Directed bench for csr_abstract_cmd: response scoreboard plus a scripted CSR responder.
module tb_csr_abstract_cmd;
  localparam int unsigned XLEN = 64;
`ifdef CSR_AC_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  logic            clk;
  logic            reset_n;
  logic            CmdValid, CmdReady, CmdWrite, Halted;
  logic [11:0]     CmdRegno;
  logic [XLEN-1:0] CmdData;
  logic            RspValid, RspReady, Busy;
  logic [XLEN-1:0] RspData;
  logic [2:0]      RspErr;
  logic            CSRReq, CSRWrite, CSRAck, CSRIllegal;
  logic [11:0]     CSRAdr;
  logic [XLEN-1:0] CSRWriteVal, CSRReadVal;

  csr_abstract_cmd #(.XLEN(XLEN), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdRegno(CmdRegno), .CmdData(CmdData), .Halted(Halted),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .Busy(Busy), .CSRReq(CSRReq), .CSRWrite(CSRWrite), .CSRAdr(CSRAdr),
    .CSRWriteVal(CSRWriteVal), .CSRAck(CSRAck), .CSRReadVal(CSRReadVal),
    .CSRIllegal(CSRIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  err;
  } rsp_t;
  rsp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Responder script and expected CSR bus fields
  int          ack_delay = 0;
  bit          ack_en    = 1'b1;
  bit          illegal   = 1'b0;
  logic [63:0] rd_val    = '0;
  int          req_cycles = 0;
  logic        exp_write = 1'b0;
  logic [11:0] exp_adr   = '0;
  logic [63:0] exp_wval  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CSR responder: checks held request fields each cycle, acks after ack_delay waits.
  initial begin
    int waited = 0;
    CSRAck = 1'b0; CSRIllegal = 1'b0; CSRReadVal = '0;
    forever begin
      @(negedge clk);
      CSRAck = 1'b0; CSRIllegal = 1'b0; CSRReadVal = '0;
      if (CSRReq === 1'b1) begin
        req_cycles++;
        chk("csr_write", 64'(CSRWrite), 64'(exp_write));
        chk("csr_adr", 64'(CSRAdr), 64'(exp_adr));
        chk("csr_wval", CSRWriteVal, exp_wval);
        if (ack_en && waited >= ack_delay) begin
          CSRAck = 1'b1; CSRIllegal = illegal; CSRReadVal = rd_val; waited = 0;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic wr, input logic [11:0] regno, input logic [63:0] data,
                      input logic halted, output int t_acc);
    int n = 0;
    @(negedge clk);
    CmdValid = 1'b1; CmdWrite = wr; CmdRegno = regno; CmdData = data; Halted = halted;
    exp_write = wr; exp_adr = regno; exp_wval = data;
    while (CmdReady !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(CmdReady), 64'd1);
    t_acc = int'(cyc);
    @(posedge clk);
    #1 CmdValid = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold, output int t_rsp);
    rsp_t e;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (RspValid !== 1'b1 && n < 400);
    t_rsp = int'(cyc);
    chk({tag, "_valid"}, 64'(RspValid), 64'd1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL %s_scoreboard: observed response expected none", tag);
      e.data = 'x; e.err = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, 64'(RspValid), 64'd1);
      chk({tag, "_hold_data"}, RspData, e.data);
      chk({tag, "_hold_cmdready"}, 64'(CmdReady), 64'd0);
      @(negedge clk);
    end
    chk({tag, "_data"}, RspData, e.data);
    chk({tag, "_err"}, 64'(RspErr), 64'(e.err));
    RspReady = 1'b1;
    @(posedge clk);
    #1 RspReady = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(RspValid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(CmdReady), 64'd1);
    chk({tag, "_idle_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    int ta, tr, rc0;
    reset_n = 1'b0; CmdValid = 1'b0; CmdWrite = 1'b0; CmdRegno = '0; CmdData = '0;
    Halted = 1'b1; RspReady = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmdready", 64'(CmdReady), 64'd0);
    chk("rst_rspvalid", 64'(RspValid), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_csrreq", 64'(CSRReq), 64'd0);
    reset_n = 1'b1;
    #1 chk("rel_cmdready_low", 64'(CmdReady), 64'd0);
    @(negedge clk);
    chk("rel_cmdready_high", 64'(CmdReady), 64'd1);

    // Legal read, immediate ack
    ack_delay = 0; rd_val = 64'h8000_0000_0014_112D;
    exp_q.push_back('{data: 64'h8000_0000_0014_112D, err: 3'd0});
    send(1'b0, 12'h301, '0, 1'b1, ta);
    get_rsp("rd301", 0, tr);
    chk("rd301_latency", 64'(tr - ta), 64'd2);

    // Legal write
    exp_q.push_back('{data: 64'h0, err: 3'd0});
    rc0 = req_cycles;
    send(1'b1, 12'h340, 64'h0000_0000_DEAD_BEEF, 1'b1, ta);
    get_rsp("wr340", 0, tr);
    chk("wr340_req_cycles", 64'(req_cycles - rc0), 64'd1);

    // Write with upper bits set, slow ack keeps request fields held
    ack_delay = 3;
    exp_q.push_back('{data: 64'h0, err: 3'd0});
    rc0 = req_cycles;
    send(1'b1, 12'h7C0, 64'hFFFF_0000_1234_5678, 1'b1, ta);
    get_rsp("wr7c0", 0, tr);
    chk("wr7c0_req_cycles", 64'(req_cycles - rc0), 64'd4);
    chk("wr7c0_latency", 64'(tr - ta), 64'd5);
    ack_delay = 0;

    // Not halted: cmderr 4, no CSR traffic
    exp_q.push_back('{data: 64'h0, err: 3'd4});
    rc0 = req_cycles;
    send(1'b0, 12'h300, '0, 1'b0, ta);
    get_rsp("nohalt", 0, tr);
    chk("nohalt_no_req", 64'(req_cycles - rc0), 64'd0);
    chk("nohalt_latency", 64'(tr - ta), 64'd1);

    // Write to read-only space: cmderr 3, no CSR traffic
    exp_q.push_back('{data: 64'h0, err: 3'd3});
    rc0 = req_cycles;
    send(1'b1, 12'hF14, 64'h1, 1'b1, ta);
    get_rsp("ro_f14", 0, tr);
    chk("ro_f14_no_req", 64'(req_cycles - rc0), 64'd0);

    // Read answered with CSRIllegal
    illegal = 1'b1; rd_val = 64'h1234;
    exp_q.push_back('{data: 64'h0, err: 3'd3});
    rc0 = req_cycles;
    send(1'b0, 12'h302, '0, 1'b1, ta);
    get_rsp("ill302", 0, tr);
    chk("ill302_req_cycles", 64'(req_cycles - rc0), 64'd1);
    illegal = 1'b0;

    // Back-pressured response with a second command pending
    rd_val = 64'h0000_0000_0000_1100;
    exp_q.push_back('{data: 64'h1100, err: 3'd0});
    send(1'b0, 12'h305, '0, 1'b1, ta);
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdRegno = 12'h7B2; CmdData = '0;
    get_rsp("bp305", 5, tr);
    exp_write = 1'b0; exp_adr = 12'h7B2; exp_wval = '0; rd_val = 64'hA5;
    exp_q.push_back('{data: 64'hA5, err: 3'd0});
    @(posedge clk);
    #1 CmdValid = 1'b0;
    @(negedge clk);
    chk("bp_second_busy", 64'(Busy), 64'd1);
    chk("bp_second_req", 64'(CSRReq), 64'd1);
    get_rsp("bp7b2", 0, tr);

`ifdef CSR_AC_TIMEOUT_EN
    // No ack: timeout after count reaches TIMEOUT
    ack_en = 1'b0;
    exp_q.push_back('{data: 64'h0, err: 3'd7});
    rc0 = req_cycles;
    send(1'b0, 12'h343, '0, 1'b1, ta);
    get_rsp("tmo", 0, tr);
    chk("tmo_req_cycles", 64'(req_cycles - rc0), 64'(TB_TIMEOUT + 1));
    ack_en = 1'b1;

    // Ack coinciding with the final count completes normally
    ack_delay = int'(TB_TIMEOUT); rd_val = 64'h77;
    exp_q.push_back('{data: 64'h77, err: 3'd0});
    send(1'b0, 12'h344, '0, 1'b1, ta);
    get_rsp("tmo_ack_wins", 0, tr);
    ack_delay = 0;
`endif

    // Reset mid-ISSUE drops the command silently
    ack_en = 1'b0;
    send(1'b1, 12'h341, 64'h55AA, 1'b1, ta);
    @(negedge clk);
    chk("mid_req_before", 64'(CSRReq), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmdready", 64'(CmdReady), 64'd0);
    chk("mid_rst_rspvalid", 64'(RspValid), 64'd0);
    chk("mid_rst_rspdata", RspData, 64'd0);
    chk("mid_rst_rsperr", 64'(RspErr), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_csrreq", 64'(CSRReq), 64'd0);
    chk("mid_rst_csrwrite", 64'(CSRWrite), 64'd0);
    chk("mid_rst_csradr", 64'(CSRAdr), 64'd0);
    chk("mid_rst_csrwval", CSRWriteVal, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(RspValid), 64'd0);
    end
    chk("post_rst_ready", 64'(CmdReady), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
